// File: rtl/mmu_tlb_if.sv
// CP0/cache-facing side of the MIPS32 joint TLB: CP0 register views, TLBR/TLBP
// results and the two independent translation request/response channels.
interface mmu_tlb_if;
   logic [31:0] EntryHi;
   logic [31:0] EntryLo0;
   logic [31:0] EntryLo1;
   logic [31:0] Index;
   logic [31:0] Random;
   logic [2:0]  K0;
   logic        tlbwi;
   logic        tlbwr;
   logic [31:0] tlb_EntryHi;
   logic [31:0] tlb_EntryLo0;
   logic [31:0] tlb_EntryLo1;
   logic [31:0] tlb_Index;
   logic        i_req;
   logic [31:0] i_vaddr;
   logic        i_valid;
   logic [31:0] i_paddr;
   logic        i_cached;
   logic        i_refill;
   logic        i_invalid;
   logic        d_req;
   logic [31:0] d_vaddr;
   logic        d_we;
   logic        d_valid;
   logic [31:0] d_paddr;
   logic        d_cached;
   logic        d_refill;
   logic        d_invalid;
   logic        d_mod;

   modport master (
      output EntryHi, EntryLo0, EntryLo1, Index, Random, K0, tlbwi, tlbwr,
      output i_req, i_vaddr, d_req, d_vaddr, d_we,
      input  tlb_EntryHi, tlb_EntryLo0, tlb_EntryLo1, tlb_Index,
      input  i_valid, i_paddr, i_cached, i_refill, i_invalid,
      input  d_valid, d_paddr, d_cached, d_refill, d_invalid, d_mod
   );

   modport slave (
      input  EntryHi, EntryLo0, EntryLo1, Index, Random, K0, tlbwi, tlbwr,
      input  i_req, i_vaddr, d_req, d_vaddr, d_we,
      output tlb_EntryHi, tlb_EntryLo0, tlb_EntryLo1, tlb_Index,
      output i_valid, i_paddr, i_cached, i_refill, i_invalid,
      output d_valid, d_paddr, d_cached, d_refill, d_invalid, d_mod
   );
endinterface

// File: rtl/mmu_tlb.sv
// 8-entry fully associative joint MIPS32 TLB: TLBWI/TLBWR writes, combinational
// TLBR/TLBP, and one-cycle registered I/D address translation.
module mmu_tlb #(
   parameter int unsigned TLB_ENTRIES = 8
) (
   input logic      clk,
   input logic      rst,
   mmu_tlb_if.slave bus
);
   localparam int unsigned IW = $clog2(TLB_ENTRIES);

   logic [18:0] vpn2_q [TLB_ENTRIES];
   logic [7:0]  asid_q [TLB_ENTRIES];
   logic        g_q    [TLB_ENTRIES];
   logic [19:0] pfn0_q [TLB_ENTRIES];
   logic [2:0]  c0_q   [TLB_ENTRIES];
   logic        d0_q   [TLB_ENTRIES];
   logic        v0_q   [TLB_ENTRIES];
   logic [19:0] pfn1_q [TLB_ENTRIES];
   logic [2:0]  c1_q   [TLB_ENTRIES];
   logic        d1_q   [TLB_ENTRIES];
   logic        v1_q   [TLB_ENTRIES];

   // Lowest matching index wins so duplicate entries resolve deterministically.
   function automatic logic [IW:0] find(input logic [18:0] vpn2, input logic [7:0] asid);
      logic [IW:0] r;
      r = '0;
      for (int unsigned e = 0; e < TLB_ENTRIES; e++) begin
         if (!r[IW] && vpn2_q[IW'(e)] == vpn2 && (g_q[IW'(e)] || asid_q[IW'(e)] == asid))
            r = {1'b1, IW'(e)};
      end
      return r;
   endfunction

   function automatic void xlate(input logic [31:0] va, input logic [7:0] asid,
                                 input logic we, input logic [2:0] k0,
                                 output logic [31:0] pa, output logic cached,
                                 output logic refill, output logic invalid, output logic mod);
      logic [IW:0]   hit;
      logic [IW-1:0] idx;
      logic [19:0]   pfn;
      logic [2:0]    c;
      logic          d, v;
      pa = '0; cached = 1'b0; refill = 1'b0; invalid = 1'b0; mod = 1'b0;
      hit = find(va[31:13], asid);
      idx = hit[IW-1:0];
      pfn = va[12] ? pfn1_q[idx] : pfn0_q[idx];
      c   = va[12] ? c1_q[idx]   : c0_q[idx];
      d   = va[12] ? d1_q[idx]   : d0_q[idx];
      v   = va[12] ? v1_q[idx]   : v0_q[idx];
      if (va[31:30] == 2'b10) begin
         // kseg0 (va[29]=0) honours K0; kseg1 is always uncached
         pa     = {3'b000, va[28:0]};
         cached = !va[29] && (k0 == 3'b011);
      end else if (!hit[IW]) begin
         refill = 1'b1;
      end else if (!v) begin
         invalid = 1'b1;
      end else if (we && !d) begin
         mod = 1'b1;
      end else begin
         pa     = {pfn, va[11:0]};
         cached = (c == 3'b011);
      end
   endfunction

   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] rd_idx;
   logic [IW:0]   probe;

   assign wr_en  = bus.tlbwi | bus.tlbwr;
   assign wr_idx = bus.tlbwi ? bus.Index[IW-1:0] : bus.Random[IW-1:0];
   assign rd_idx = bus.Index[IW-1:0];
   assign probe  = find(bus.EntryHi[31:13], bus.EntryHi[7:0]);

   assign bus.tlb_EntryHi  = {vpn2_q[rd_idx], 5'b0, asid_q[rd_idx]};
   assign bus.tlb_EntryLo0 = {6'b0, pfn0_q[rd_idx], c0_q[rd_idx], d0_q[rd_idx], v0_q[rd_idx], g_q[rd_idx]};
   assign bus.tlb_EntryLo1 = {6'b0, pfn1_q[rd_idx], c1_q[rd_idx], d1_q[rd_idx], v1_q[rd_idx], g_q[rd_idx]};
   assign bus.tlb_Index    = probe[IW] ? {{(32-IW){1'b0}}, probe[IW-1:0]} : 32'h8000_0000;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned e = 0; e < TLB_ENTRIES; e++) begin
            g_q[IW'(e)]  <= 1'b0;
            v0_q[IW'(e)] <= 1'b0;
            v1_q[IW'(e)] <= 1'b0;
         end
      end else if (wr_en) begin
         vpn2_q[wr_idx] <= bus.EntryHi[31:13];
         asid_q[wr_idx] <= bus.EntryHi[7:0];
         g_q[wr_idx]    <= bus.EntryLo0[0] & bus.EntryLo1[0];
         pfn0_q[wr_idx] <= bus.EntryLo0[25:6];
         c0_q[wr_idx]   <= bus.EntryLo0[5:3];
         d0_q[wr_idx]   <= bus.EntryLo0[2];
         v0_q[wr_idx]   <= bus.EntryLo0[1];
         pfn1_q[wr_idx] <= bus.EntryLo1[25:6];
         c1_q[wr_idx]   <= bus.EntryLo1[5:3];
         d1_q[wr_idx]   <= bus.EntryLo1[2];
         v1_q[wr_idx]   <= bus.EntryLo1[1];
      end
   end

   logic [31:0] i_paddr_d, d_paddr_d;
   logic        i_cached_d, i_refill_d, i_invalid_d, i_mod_unused;
   logic        d_cached_d, d_refill_d, d_invalid_d, d_mod_d;

   always_comb begin
      xlate(bus.i_vaddr, bus.EntryHi[7:0], 1'b0, bus.K0,
            i_paddr_d, i_cached_d, i_refill_d, i_invalid_d, i_mod_unused);
      xlate(bus.d_vaddr, bus.EntryHi[7:0], bus.d_we, bus.K0,
            d_paddr_d, d_cached_d, d_refill_d, d_invalid_d, d_mod_d);
   end

   logic [31:0] i_paddr_q, d_paddr_q;
   logic        i_valid_q, i_cached_q, i_refill_q, i_invalid_q;
   logic        d_valid_q, d_cached_q, d_refill_q, d_invalid_q, d_mod_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         i_valid_q <= 1'b0; i_paddr_q <= '0; i_cached_q <= 1'b0;
         i_refill_q <= 1'b0; i_invalid_q <= 1'b0;
         d_valid_q <= 1'b0; d_paddr_q <= '0; d_cached_q <= 1'b0;
         d_refill_q <= 1'b0; d_invalid_q <= 1'b0; d_mod_q <= 1'b0;
      end else begin
         i_valid_q   <= bus.i_req;
         i_paddr_q   <= bus.i_req ? i_paddr_d : '0;
         i_cached_q  <= bus.i_req & i_cached_d;
         i_refill_q  <= bus.i_req & i_refill_d;
         i_invalid_q <= bus.i_req & i_invalid_d;
         d_valid_q   <= bus.d_req;
         d_paddr_q   <= bus.d_req ? d_paddr_d : '0;
         d_cached_q  <= bus.d_req & d_cached_d;
         d_refill_q  <= bus.d_req & d_refill_d;
         d_invalid_q <= bus.d_req & d_invalid_d;
         d_mod_q     <= bus.d_req & d_mod_d;
      end
   end

   assign bus.i_valid   = i_valid_q;
   assign bus.i_paddr   = i_paddr_q;
   assign bus.i_cached  = i_cached_q;
   assign bus.i_refill  = i_refill_q;
   assign bus.i_invalid = i_invalid_q;
   assign bus.d_valid   = d_valid_q;
   assign bus.d_paddr   = d_paddr_q;
   assign bus.d_cached  = d_cached_q;
   assign bus.d_refill  = d_refill_q;
   assign bus.d_invalid = d_invalid_q;
   assign bus.d_mod     = d_mod_q;

   logic unused_bits;
   assign unused_bits = ^{bus.EntryHi[12:8], bus.EntryLo0[31:26], bus.EntryLo1[31:26],
                          bus.Index[31:IW], bus.Random[31:IW], i_mod_unused};
endmodule
